// File: rtl/floppy_pkg.sv
// Shared constants for the floppy write path: GCR address-mark bytes and the
// state encoding of the address-mark detector.
package floppy_pkg;

  localparam logic [7:0] GCR_MARK0 = 8'hD5;
  localparam logic [7:0] GCR_MARK1 = 8'hAA;
  localparam logic [7:0] GCR_MARK2 = 8'h96;

  localparam logic [1:0] MARK_IDLE   = 2'd0;
  localparam logic [1:0] MARK_GOT_D5 = 2'd1;
  localparam logic [1:0] MARK_GOT_AA = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = MARK_IDLE,
    ST_GOT_D5 = MARK_GOT_D5,
    ST_GOT_AA = MARK_GOT_AA
  } mark_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible on o_dout whenever
// o_empty is low. Full/empty derive from the occupancy counter.
module sync_fifo_fwft #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [AW:0]      o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/gcr_write_byte_buffer.sv
// Buffers bytes from the GCR write decoder for the MCU, tags the first byte
// after each sync run, detects the D5 AA 96 address mark and flags overflow.
module gcr_write_byte_buffer
  import floppy_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        writeEnable,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  input  logic        syncSeen,
  output logic [7:0]  wrData,
  output logic        wrFirst,
  output logic        wrByteReady,
  input  logic        mcuAck,
  output logic        markFound,
  output logic        overflow,
  output logic [AW:0] fifoCount,
  output mark_state_e o_dbg_mark_state
);

  // MCU handshake: wrByteReady high means wrData/wrFirst hold the head byte;
  // a one-cycle mcuAck while wrByteReady is high consumes it, an ack while
  // wrByteReady is low does nothing.
  logic [8:0]  w_head;
  logic [AW:0] w_count;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_tag;
  logic        w_mark_hit;
  mark_state_e w_mark_next;

  logic        r_first_pending;
  logic        r_overflow;
  logic        r_we_d;
  logic        r_mark_found;
  mark_state_e r_mark_state;

  assign w_pop  = mcuAck && !w_empty;
  assign w_push = byteValid && writeEnable && (!w_full || w_pop);
  assign w_drop = byteValid && writeEnable && w_full && !w_pop;
  // A sync arriving with a byte belongs to the byte after it.
  assign w_tag  = r_first_pending && !syncSeen;

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (9),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (!writeEnable),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({w_tag, byteIn}),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_first_pending <= 1'b0;
      r_overflow      <= 1'b0;
      r_we_d          <= 1'b0;
    end else begin
      r_we_d <= writeEnable;
      if (!writeEnable)  r_first_pending <= 1'b0;
      else if (syncSeen) r_first_pending <= 1'b1;
      else if (w_push)   r_first_pending <= 1'b0;
      // Sticky across write-gate low; a fresh write gate clears it.
      if (w_drop)                         r_overflow <= 1'b1;
      else if (writeEnable && !r_we_d)    r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mark_state <= ST_IDLE;
      r_mark_found <= 1'b0;
    end else begin
      r_mark_state <= w_mark_next;
      r_mark_found <= w_mark_hit;
    end
  end

  // Dropped bytes still advance the detector: the mark is about the disk stream.
  always_comb begin
    w_mark_next = r_mark_state;
    w_mark_hit  = 1'b0;
    if (!writeEnable || syncSeen) begin
      w_mark_next = ST_IDLE;
    end else if (byteValid) begin
      unique case (r_mark_state)
        ST_IDLE:   w_mark_next = (byteIn == GCR_MARK0) ? ST_GOT_D5 : ST_IDLE;
        ST_GOT_D5: begin
          if (byteIn == GCR_MARK1)      w_mark_next = ST_GOT_AA;
          else if (byteIn == GCR_MARK0) w_mark_next = ST_GOT_D5;
          else                          w_mark_next = ST_IDLE;
        end
        ST_GOT_AA: begin
          if (byteIn == GCR_MARK2) begin
            w_mark_next = ST_IDLE;
            w_mark_hit  = 1'b1;
          end else if (byteIn == GCR_MARK0) begin
            w_mark_next = ST_GOT_D5;
          end else begin
            w_mark_next = ST_IDLE;
          end
        end
        default:   w_mark_next = ST_IDLE;
      endcase
    end
  end

  assign wrByteReady      = !w_empty;
  assign wrData           = w_empty ? 8'h00 : w_head[7:0];
  assign wrFirst          = !w_empty && w_head[8];
  assign markFound        = r_mark_found;
  assign overflow         = r_overflow;
  assign fifoCount        = w_count;
  assign o_dbg_mark_state = r_mark_state;

endmodule

// File: tb/tb_gcr_write_byte_buffer.sv
// Self-checking bench for gcr_write_byte_buffer: directed scenarios plus a
// randomized stream, all checked against a queue-based reference model.
module tb_gcr_write_byte_buffer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       writeEnable;
  logic [7:0] byteIn;
  logic       byteValid;
  logic       syncSeen;
  logic [7:0] wrData;
  logic       wrFirst;
  logic       wrByteReady;
  logic       mcuAck;
  logic       markFound;
  logic       overflow;
  logic [2:0] fifoCount;
  logic [1:0] dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: FIFO contents as {first, byte}, recent bytes seen by the
  // mark detector, pending-first flag, sticky overflow, mark pulse.
  logic [8:0] exp_q[$];
  logic [7:0] hist[$];
  logic       m_pending;
  logic       m_ovf;
  logic       m_mark;
  logic       m_we_prev;

  gcr_write_byte_buffer #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .writeEnable      (writeEnable),
    .byteIn           (byteIn),
    .byteValid        (byteValid),
    .syncSeen         (syncSeen),
    .wrData           (wrData),
    .wrFirst          (wrFirst),
    .wrByteReady      (wrByteReady),
    .mcuAck           (mcuAck),
    .markFound        (markFound),
    .overflow         (overflow),
    .fifoCount        (fifoCount),
    .o_dbg_mark_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #70 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    m_pending = 1'b0;
    m_ovf     = 1'b0;
    m_mark    = 1'b0;
    m_we_prev = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic bv, input logic [7:0] b,
                            input logic sync, input logic ack);
    logic pop, push, full;
    if (we && !m_we_prev) m_ovf = 1'b0;
    m_mark = 1'b0;
    if (!we) begin
      exp_q.delete();
      hist.delete();
      m_pending = 1'b0;
    end else begin
      pop  = ack && (exp_q.size() != 0);
      full = (exp_q.size() == DEPTH);
      push = bv && (!full || pop);
      if (bv && full && !pop) m_ovf = 1'b1;
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({m_pending && !sync, b});
      if (sync) m_pending = 1'b1;
      else if (push) m_pending = 1'b0;
      if (sync) begin
        hist.delete();
      end else if (bv) begin
        hist.push_back(b);
        if (hist.size() > 3) void'(hist.pop_front());
        if (hist.size() == 3 && hist[0] == 8'hD5 && hist[1] == 8'hAA && hist[2] == 8'h96) begin
          m_mark = 1'b1;
          hist.delete();
        end
      end
    end
    m_we_prev = we;
  endtask

  function automatic logic [14:0] exp_vec();
    logic [7:0] d;
    logic       f;
    d = 8'h00;
    f = 1'b0;
    if (exp_q.size() != 0) begin
      d = exp_q[0][7:0];
      f = exp_q[0][8];
    end
    return {d, f, exp_q.size() != 0, m_mark, m_ovf, 3'(exp_q.size())};
  endfunction

  function automatic logic [14:0] obs_vec();
    return {wrData, wrFirst, wrByteReady, markFound, overflow, fifoCount};
  endfunction

  // Driver: apply inputs, take one edge, advance the model, settle.
  task automatic step(input logic we, input logic bv, input logic [7:0] b,
                      input logic sync, input logic ack);
    writeEnable = we;
    byteValid   = bv;
    byteIn      = b;
    syncSeen    = sync;
    mcuAck      = ack;
    @(posedge clk);
    model_edge(we, bv, b, sync, ack);
    #1;
  endtask

  task automatic clean();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [7:0] pre [5] = '{8'h00, 8'h00, 8'hD5, 8'hAA, 8'h12};
    reset = 1'b1; writeEnable = 1'b0; byteValid = 1'b0; byteIn = 8'h00;
    syncSeen = 1'b0; mcuAck = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    n_cmp++;
    if (obs_vec() !== 15'd0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_initial got=%h/%0d want=0000/0", obs_vec(), dbg_state);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, i >= 2, pre[i], i == 1, 1'b0);
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_prestream got=%h want=%h", obs_vec(), exp_vec());
    end
    reset = 1'b1; byteValid = 1'b1; byteIn = 8'hD5;
    @(posedge clk);
    model_reset();
    #1;
    n_cmp++;
    if (obs_vec() !== 15'd0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_midstream got=%h/%0d want=0000/0", obs_vec(), dbg_state);
    end
    reset = 1'b0;
    step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    n_cmp++;
    if (wrData !== 8'h3C || wrByteReady !== 1'b1 || fifoCount !== 3'd1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_first_byte got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_mark();
    logic [7:0] bytes [3] = '{8'hD5, 8'hAA, 8'h96};
    logic [8:0] pops  [3] = '{9'h1D5, 9'h0AA, 9'h096};
    int pulses;
    clean();
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, bytes[i], 1'b0, 1'b0);
      pulses += int'(markFound);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL mark_stream[%0d] got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (markFound !== 1'b1) begin
      n_fail++;
      $display("FAIL mark_pulse_timing got=%b want=1", markFound);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      pulses += int'(markFound);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL mark_pulse_count got=%0d want=1", pulses);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({wrFirst, wrData} !== pops[i]) begin
        n_fail++;
        $display("FAIL mark_pop[%0d] got=%h want=%h", i, {wrFirst, wrData}, pops[i]);
      end
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    end
  endtask

  task automatic test_mark_variants();
    // bit 8 marks a syncSeen cycle without a byte
    logic [8:0] seqs [3][4] = '{'{9'h0D5, 9'h0D5, 9'h0AA, 9'h096},
                                '{9'h0D5, 9'h0AA, 9'h055, 9'h096},
                                '{9'h0D5, 9'h0AA, 9'h100, 9'h096}};
    int want [3] = '{1, 0, 0};
    int cnt;
    for (int c = 0; c < 3; c++) begin
      clean();
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
        step(1'b1, !seqs[c][i][8], seqs[c][i][7:0], seqs[c][i][8], 1'b0);
        cnt += int'(markFound);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL variant%0d_step%0d got=%h want=%h", c, i, obs_vec(), exp_vec());
        end
      end
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      cnt += int'(markFound);
      n_cmp++;
      if (cnt != want[c]) begin
        n_fail++;
        $display("FAIL variant%0d_marks got=%0d want=%0d", c, cnt, want[c]);
      end
    end
  endtask

  task automatic test_overflow();
    clean();
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    n_cmp++;
    if (fifoCount !== 3'd4 || overflow !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL ovf_full got count=%0d ovf=%b want count=4 ovf=1", fifoCount, overflow);
    end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (wrData !== 8'(i)) begin
        n_fail++;
        $display("FAIL ovf_pop[%0d] got=%h want=%h", i, wrData, 8'(i));
      end
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_hold_we_low got=%b want=1", overflow);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (overflow !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL ovf_clear_we_rise got=%b want=0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] last;
    clean();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    n_cmp++;
    if (fifoCount !== 3'd4 || overflow !== 1'b0 || wrData !== 8'hA2) begin
      n_fail++;
      $display("FAIL full_pushpop got count=%0d ovf=%b head=%h want 4/0/a2", fifoCount, overflow, wrData);
    end
    last = 8'h00;
    for (int i = 0; i < 4; i++) begin
      last = wrData;
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    n_cmp++;
    if (last !== 8'h77 || wrByteReady !== 1'b0) begin
      n_fail++;
      $display("FAIL full_last_pop got=%h ready=%b want=77 ready=0", last, wrByteReady);
    end
  endtask

  task automatic test_flush();
    clean();
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (wrByteReady !== 1'b0 || fifoCount !== 3'd0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL flush got ready=%b count=%0d want ready=0 count=0", wrByteReady, fifoCount);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (fifoCount !== 3'd0 || wrByteReady !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL ack_empty got=%h want=%h", obs_vec(), exp_vec());
    end
    step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    n_cmp++;
    if ({wrFirst, wrData} !== 9'h05A) begin
      n_fail++;
      $display("FAIL flush_pending_cleared got=%h want=05a", {wrFirst, wrData});
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       we, bv, sync, ack;
    clean();
    for (int i = 0; i < 400; i++) begin
      we   = ($urandom_range(0, 19) != 0);
      bv   = ($urandom_range(0, 9) < 5);
      sync = ($urandom_range(0, 19) == 0);
      ack  = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 3))
        0:       b = 8'hD5;
        1:       b = 8'hAA;
        2:       b = 8'h96;
        default: b = 8'($urandom_range(0, 255));
      endcase
      step(we, bv, b, sync, ack);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mark();
    test_mark_variants();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
